// File: rtl/idecode_pipe.sv
// idecode_pipe - instruction-decode pipeline stage for the bexkat1 core.
//
// Picks the source register indices out of the instruction word, reads a
// flop-based register file with writeback forwarding, and registers the
// instruction, PC, indices and operands behind a valid/ready handshake.
// While an instruction is stalled, writebacks to its source registers are
// merged into the held operands so they never go stale.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   valid_i / ready_o      fetch-side handshake
//   ir_i, pc_i             instruction word and its PC
//   flush_i                drop held instruction and current input
//   valid_o / ready_i      execute-side handshake
//   ir_o, pc_o             registered instruction and PC
//   src1_o, src2_o         registered source indices
//   reg_data_out1/2        registered operands
//   reg_write              per-16-bit-lane writeback enables
//   reg_write_addr         writeback register index
//   reg_data_in            writeback data

module idecode_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int IR_W   = 64,
  localparam int LANES = DATA_W / 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [IR_W-1:0]   ir_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [IR_W-1:0]   ir_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [3:0]        src1_o,
  output logic [3:0]        src2_o,
  output logic [DATA_W-1:0] reg_data_out1,
  output logic [DATA_W-1:0] reg_data_out2,
  input  logic [LANES-1:0]  reg_write,
  input  logic [3:0]        reg_write_addr,
  input  logic [DATA_W-1:0] reg_data_in
);

  // Compare-class instruction type from the bexkat1 definitions; compares
  // read ra/rb instead of rb/rc.
  localparam logic [3:0] T_CMP = 4'h3;

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [3:0] IDX_MASK = 4'(NREGS - 1);

  // Replace the enabled 16-bit lanes of old_v with those of new_v.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [LANES-1:0]  en
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int k = 0; k < LANES; k++) begin
      if (en[k]) r[16*k +: 16] = new_v[16*k +: 16];
    end
    return r;
  endfunction

  // State
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic              valid_q, valid_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [3:0]        src1_q, src1_d;
  logic [3:0]        src2_q, src2_d;
  logic [DATA_W-1:0] rdo1_q, rdo1_d;
  logic [DATA_W-1:0] rdo2_q, rdo2_d;

  // Decode
  logic [3:0]        ir_type;
  logic [3:0]        rd_idx1, rd_idx2;
  logic [3:0]        wr_idx;
  logic [DATA_W-1:0] rd_val1, rd_val2;
  logic              advance;
  logic              hold;

  assign ready_o = !valid_q || ready_i;
  assign advance = valid_i && ready_o;
  assign hold    = valid_q && !ready_i;

  assign ir_type = ir_i[31:28];

  always_comb begin
    rd_idx1 = ir_i[19:16];
    rd_idx2 = ir_i[15:12];
    if (ir_type == T_CMP) begin
      rd_idx1 = ir_i[23:20];
      rd_idx2 = ir_i[19:16];
    end
    rd_idx1 = rd_idx1 & IDX_MASK;
    rd_idx2 = rd_idx2 & IDX_MASK;
  end

  assign wr_idx = reg_write_addr & IDX_MASK;

  // Write-through read: a writeback landing this edge is visible now.
  always_comb begin
    rd_val1 = rf_q[rd_idx1[AW-1:0]];
    rd_val2 = rf_q[rd_idx2[AW-1:0]];
    if (wr_idx == rd_idx1) rd_val1 = lane_merge(rd_val1, reg_data_in, reg_write);
    if (wr_idx == rd_idx2) rd_val2 = lane_merge(rd_val2, reg_data_in, reg_write);
  end

  always_comb begin
    rf_d = rf_q;
    rf_d[wr_idx[AW-1:0]] = lane_merge(rf_q[wr_idx[AW-1:0]], reg_data_in, reg_write);
  end

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    rdo1_d  = rdo1_q;
    rdo2_d  = rdo2_q;

    if (flush_i) begin
      valid_d = 1'b0;
    end else if (advance) begin
      valid_d = 1'b1;
      ir_d    = ir_i;
      pc_d    = pc_i;
      src1_d  = rd_idx1;
      src2_d  = rd_idx2;
      rdo1_d  = rd_val1;
      rdo2_d  = rd_val2;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    // A stalled instruction tracks writebacks to its sources. hold implies
    // ready_o=0, so this never collides with a capture.
    if (hold) begin
      if (wr_idx == src1_q) rdo1_d = lane_merge(rdo1_q, reg_data_in, reg_write);
      if (wr_idx == src2_q) rdo2_d = lane_merge(rdo2_q, reg_data_in, reg_write);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      rdo1_q  <= '0;
      rdo2_q  <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      rdo1_q  <= rdo1_d;
      rdo2_q  <= rdo2_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign valid_o       = valid_q;
  assign ir_o          = ir_q;
  assign pc_o          = pc_q;
  assign src1_o        = src1_q;
  assign src2_o        = src2_q;
  assign reg_data_out1 = rdo1_q;
  assign reg_data_out2 = rdo2_q;

endmodule

// File: tb/tb_idecode_pipe.sv
// Directed bench for idecode_pipe: decode, compare select, lane forwarding,
// stall hold updates, flush, streaming and asynchronous reset.

module tb_idecode_pipe;

  localparam int DATA_W = 32;
  localparam int IR_W   = 64;
  localparam int LANES  = DATA_W / 16;
  localparam logic [3:0] T_CMP = 4'h3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic              ready_o;
  logic [IR_W-1:0]   ir_i;
  logic [DATA_W-1:0] pc_i;
  logic              flush_i;
  logic              ready_i;
  logic              valid_o;
  logic [IR_W-1:0]   ir_o;
  logic [DATA_W-1:0] pc_o;
  logic [3:0]        src1_o, src2_o;
  logic [DATA_W-1:0] reg_data_out1, reg_data_out2;
  logic [LANES-1:0]  reg_write;
  logic [3:0]        reg_write_addr;
  logic [DATA_W-1:0] reg_data_in;

  int checks = 0;
  int errors = 0;

  idecode_pipe #(.DATA_W(DATA_W), .NREGS(16), .IR_W(IR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_i(valid_i), .ready_o(ready_o), .ir_i(ir_i), .pc_i(pc_i),
    .flush_i(flush_i), .ready_i(ready_i), .valid_o(valid_o),
    .ir_o(ir_o), .pc_o(pc_o), .src1_o(src1_o), .src2_o(src2_o),
    .reg_data_out1(reg_data_out1), .reg_data_out2(reg_data_out2),
    .reg_write(reg_write), .reg_write_addr(reg_write_addr),
    .reg_data_in(reg_data_in)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [IR_W-1:0] mk(input logic [3:0] t, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
    return {32'hA5A5_0000, t, 4'h0, ra, rb, rc, 12'h0};
  endfunction

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [1:0] en);
    reg_write = en; reg_write_addr = a; reg_data_in = d;
    step();
    reg_write = '0;
  endtask

  // Read a register through the decode path (rb slot -> reg_data_out1).
  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    valid_i = 1'b1; ir_i = mk(4'h0, 4'h0, a, 4'h0); pc_i = 32'hF00; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk(tag, reg_data_out1, exp);
    step();
  endtask

  logic [IR_W-1:0] ir_hold;

  initial begin
    rst_i = 1'b1; valid_i = 0; ir_i = '0; pc_i = '0; flush_i = 0; ready_i = 0;
    reg_write = '0; reg_write_addr = '0; reg_data_in = '0;
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_out1", reg_data_out1, 0);
    chk("rst_ready", ready_o, 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();

    // Basic decode
    wr(4'd2, 32'h1111_2222, 2'b11);
    wr(4'd3, 32'h3333_4444, 2'b11);
    valid_i = 1; ready_i = 1; ir_i = mk(4'h0, 4'd9, 4'd2, 4'd3); pc_i = 32'h100;
    step();
    chk("dec_valid", valid_o, 1);
    chk("dec_out1", reg_data_out1, 32'h1111_2222);
    chk("dec_out2", reg_data_out2, 32'h3333_4444);
    chk("dec_pc", pc_o, 32'h100);
    chk("dec_src1", src1_o, 2);
    chk("dec_src2", src2_o, 3);
    chk("dec_ir", ir_o, mk(4'h0, 4'd9, 4'd2, 4'd3));

    // Compare select: ra/rb, rc ignored
    ir_i = mk(T_CMP, 4'd2, 4'd3, 4'd9); pc_i = 32'h104;
    step();
    valid_i = 0;
    chk("cmp_src1", src1_o, 2);
    chk("cmp_src2", src2_o, 3);
    chk("cmp_out1", reg_data_out1, 32'h1111_2222);
    chk("cmp_out2", reg_data_out2, 32'h3333_4444);

    // Consumed without new input: valid drops, data kept
    step();
    chk("drain_valid", valid_o, 0);
    chk("drain_pc", pc_o, 32'h104);

    // Same-cycle forward with upper-lane mask
    wr(4'd5, 32'hAAAA_BBBB, 2'b11);
    valid_i = 1; ir_i = mk(4'h0, 4'd0, 4'd5, 4'd0); pc_i = 32'h108;
    reg_write = 2'b10; reg_write_addr = 4'd5; reg_data_in = 32'h1234_5678;
    step();
    valid_i = 0; reg_write = '0;
    chk("fwd_out1", reg_data_out1, 32'h1234_BBBB);
    step();
    rd("fwd_rf", 4'd5, 32'h1234_BBBB);

    // Stall with hold update
    valid_i = 1; ready_i = 1; ir_i = mk(4'h0, 4'd0, 4'd7, 4'd1); pc_i = 32'h200;
    ir_hold = ir_i;
    step();
    valid_i = 0; ready_i = 0; ir_i = '0; pc_i = 32'hBAD;
    #1;
    chk("stall_ready0", ready_o, 0);
    chk("stall_out1_0", reg_data_out1, 0);
    step();
    chk("stall_ready1", ready_o, 0);
    reg_write = 2'b11; reg_write_addr = 4'd7; reg_data_in = 32'hDEAD_BEEF;
    step();
    reg_write = '0;
    chk("stall_out1_upd", reg_data_out1, 32'hDEAD_BEEF);
    chk("stall_ir", ir_o, ir_hold);
    chk("stall_pc", pc_o, 32'h200);
    chk("stall_ready2", ready_o, 0);
    chk("stall_valid", valid_o, 1);
    step();
    chk("stall_out1_keep", reg_data_out1, 32'hDEAD_BEEF);
    ready_i = 1;
    #1;
    chk("stall_release_ready", ready_o, 1);
    step();
    chk("stall_drained", valid_o, 0);

    // Stall with src1 == src2: both operands follow a low-lane write
    valid_i = 1; ir_i = mk(T_CMP, 4'd6, 4'd6, 4'd0); pc_i = 32'h240;
    step();
    valid_i = 0; ready_i = 0;
    reg_write = 2'b01; reg_write_addr = 4'd6; reg_data_in = 32'h5555_CAFE;
    step();
    reg_write = '0;
    chk("same_out1", reg_data_out1, 32'h0000_CAFE);
    chk("same_out2", reg_data_out2, 32'h0000_CAFE);
    ready_i = 1;
    step();

    // Flush with concurrent writeback
    valid_i = 1; ir_i = mk(4'h0, 4'd0, 4'd2, 4'd0); pc_i = 32'h300;
    step();
    chk("fl_pre_valid", valid_o, 1);
    ir_i = mk(4'h0, 4'd0, 4'd3, 4'd0); pc_i = 32'h400; flush_i = 1;
    reg_write = 2'b11; reg_write_addr = 4'd9; reg_data_in = 32'h9999_0000;
    step();
    flush_i = 0; valid_i = 0; reg_write = '0;
    chk("fl_valid", valid_o, 0);
    chk("fl_pc", pc_o, 32'h300);
    chk("fl_out1", reg_data_out1, 32'h1111_2222);
    rd("fl_rf", 4'd9, 32'h9999_0000);

    // Back-to-back stream of 8
    ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1; ir_i = mk(4'h0, 4'd0, (i % 2 == 0) ? 4'd2 : 4'd3, 4'd0);
      pc_i = 32'h1000 + 32'(4 * i);
      step();
      chk("b2b_valid", valid_o, 1);
      chk("b2b_pc", pc_o, 64'(32'h1000 + 32'(4 * i)));
      chk("b2b_out1", reg_data_out1, (i % 2 == 0) ? 32'h1111_2222 : 32'h3333_4444);
    end
    valid_i = 0; ready_i = 0;

    // Asynchronous reset mid-stall
    #2;
    rst_i = 1;
    #1;
    chk("ar_valid", valid_o, 0);
    chk("ar_pc", pc_o, 0);
    chk("ar_ir", ir_o, 0);
    chk("ar_out1", reg_data_out1, 0);
    chk("ar_src1", src1_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    step();
    rd("ar_rf2", 4'd2, 0);
    rd("ar_rf5", 4'd5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idecode_pipe.md
# idecode_pipe

Parametrised instruction-decode pipeline stage for the bexkat1 core. It sits between fetch and execute. It selects source registers from the instruction word and reads a flop-based register file. Writeback results are forwarded into the read path, and the instruction, PC and operands are registered behind a valid/ready handshake with stall and flush. Operands held during a stall stay coherent with writebacks that land while the instruction waits.

## Interface
Parameters:
- DATA_W, 32, register and PC width; multiple of 16.
- NREGS, 16, number of architectural registers; power of two, at most 16.
- IR_W, 64, instruction word width; at least 32.
- LANES, DATA_W/16, number of 16-bit write-enable lanes (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  fetch presents ir_i/pc_i.
- ready_o  out  1  stage accepts input this cycle.
- ir_i  in  IR_W  instruction word.
- pc_i  in  DATA_W  PC of ir_i.
- flush_i  in  1  discard the held instruction and drop the current input.
- ready_i  in  1  execute accepts the output this cycle.
- valid_o  out  1  outputs hold a live instruction.
- ir_o  out  IR_W  registered instruction.
- pc_o  out  DATA_W  registered PC.
- src1_o, src2_o  out  4 each  registered source indices.
- reg_data_out1, reg_data_out2  out  DATA_W each  registered operands.
- reg_write  in  LANES  per-lane write enable; bit k covers bits [16k+15:16k].
- reg_write_addr  in  4  writeback register index.
- reg_data_in  in  DATA_W  writeback data.

## Operation
- Fields:
  - type = ir_i[31:28]
  - ra = ir_i[23:20]
  - rb = ir_i[19:16]
  - rc = ir_i[15:12]
- Source select:
  - Default: read1 = rb, read2 = rc.
  - When type == T_CMP (from bexkat1Def): read1 = ra, read2 = rb.
- Index masking: read indices and reg_write_addr are masked to log2(NREGS) bits.
- Register file:
  - NREGS x DATA_W flops.
  - Lane k of reg_write_addr is written on a clock edge when reg_write[k]=1; other lanes are unchanged.
- Forwarding: the combinational read value equals the register contents with every enabled lane of reg_data_in substituted when reg_write_addr matches the read index (write-through).
- Handshake:
  - advance = valid_i && ready_o.
  - ready_o = !valid_o || ready_i.
- On advance: capture ir_i, pc_i, the selected indices, the forwarded operands, and set valid_o=1.
- Output consumed without a new input (valid_o && ready_i && !advance): valid_o clears. The data outputs keep their last values.
- Hold (valid_o && !ready_i):
  - ir_o, pc_o and src*_o are frozen.
  - On any cycle where reg_write lanes hit src1_o (or src2_o), those lanes of reg_data_out1 (or reg_data_out2) are updated from reg_data_in.
  - If src1_o == src2_o, both operands update.
- Flush:
  - Highest priority: valid_o clears next edge; no capture happens; ready_o is still computed normally.
  - Register-file writes on a flush cycle still occur.
- Reset values:
  - valid_o=0, ir_o=0, pc_o=0, src1_o=0, src2_o=0, reg_data_out1=0, reg_data_out2=0.
  - All registers = 0.

## Timing
- Latency: one cycle from accepted input to valid_o.
- Throughput: one instruction per cycle when ready_i stays high.
- ready_o is combinational from valid_o and ready_i only. There is no combinational path from valid_i, ir_i or flush_i to ready_o.
- A write on the same edge as an advance is visible in the captured operand (forwarding). A write on the edge after capture is applied by the hold-update rule if the stage is still stalled, and otherwise by execute-stage forwarding (outside this block).
- Simultaneous advance and writeback to the same register: the captured operand reflects the new lanes. The register file also updates.
- rst_i asserted mid-stall: all outputs return to their reset values asynchronously. The first accept after release behaves as from idle.

## Test plan
- Basic decode: write r2=0x11112222 and r3=0x33334444, then present ir_i with rb=2, rc=3, type≠T_CMP, pc=0x100, ready_i=1 -> next cycle valid_o=1, reg_data_out1=0x11112222, reg_data_out2=0x33334444, pc_o=0x100.
- CMP select: type=T_CMP, ra=2, rb=3 -> src1_o=2, src2_o=3 with the same operand values; the rc field is ignored.
- Same-cycle forward with lane mask: r5=0xAAAABBBB; present rb=5 while reg_write=2'b10, addr=5, data=0x12345678 -> reg_data_out1=0x1234BBBB, and r5 afterwards reads 0x1234BBBB.
- Stall hold with update: capture rb=7 (value 0), drop ready_i for 3 cycles, and write r7=0xDEADBEEF in the second stall cycle -> ir_o/pc_o unchanged, reg_data_out1=0xDEADBEEF before ready_i returns, ready_o=0 throughout the stall.
- Flush: flush_i=1 while valid_o=1 and valid_i=1 -> valid_o=0 next cycle; the input is not captured; a concurrent writeback still lands.
- Back-to-back and reset: stream 8 instructions with ready_i=1 -> 8 consecutive valid_o cycles in order. Asserting rst_i mid-stream -> valid_o=0 and all outputs 0 immediately; after release, the register file reads 0.
